// File: rtl/systolic_pkg.sv
// Shared types for the systolic operand feeder. No logic, so no latency or backpressure.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        BUFFER = 2'd2,
        STREAM = 2'd3
    } feeder_state_t;

    localparam int DEF_MATRIX_SIZE = 4;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int ARRAY_SIZE      = 2 * DEF_MATRIX_SIZE - 1;

    typedef logic [DEF_MATRIX_SIZE-1:0][DEF_DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/systolic_skew_line.sv
// Zero-reset delay chain of DEPTH stages; latency DEPTH cycles (DEPTH=0 is a wire).
// No backpressure: shifts every cycle.
module skew_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign q_o = d_i;
        end else begin : g_chain
            logic [DEPTH-1:0][DATA_WIDTH-1:0] sh_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sh_q <= '0;
                end else begin
                    sh_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        sh_q[i] <= sh_q[i-1];
                    end
                end
            end

            assign q_o = sh_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// Fetches an NxN tile per channel from BRAM and emits diagonally skewed lanes (row or column order).
// Latency: first element 2+RD_LAT cycles after start (+N in transpose); no backpressure, start ignored while busy.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int VECTOR      = 2,
    parameter int BRAM_DEPTH  = 2,
    parameter int RD_LAT      = 1
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 start,
    input  logic                                                 mode,
    input  logic [BRAM_DEPTH-1:0]                                base_addr,
    output logic                                                 bram_en,
    output logic [BRAM_DEPTH-1:0]                                bram_addr,
    input  logic [VECTOR-1:0][MATRIX_SIZE*DATA_WIDTH-1:0]        bram_dout,
    output logic [VECTOR-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0]   lane_out,
    output logic                                                 out_valid,
    output logic                                                 compute_start,
    output logic                                                 busy,
    output logic                                                 done
);

    localparam int N  = MATRIX_SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(3 * N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] LAST_WIN = CW'(3 * N - 3);

    feeder_state_t           state_q, state_d;
    logic                    mode_q, mode_d;
    logic [BRAM_DEPTH-1:0]   base_q, base_d;
    logic [IW-1:0]           fetch_q, fetch_d;
    logic [IW-1:0]           row_q, row_d;
    logic [IW-1:0]           col_q, col_d;
    logic                    col_act_q, col_act_d;
    logic [CW-1:0]           win_q, win_d;
    logic                    win_act_q, win_act_d;
    logic                    done_q, done_d;
    logic [RD_LAT-1:0]       en_pipe_q;

    logic row_vld, row_last, win_start, win_end;

    // A returning read is marked by the enable delayed by the BRAM latency.
    assign row_vld   = en_pipe_q[RD_LAT-1];
    assign row_last  = row_vld && (row_q == LAST_IDX);
    assign win_start = mode_q ? (col_act_q && (col_q == '0)) : (row_vld && (row_q == '0));
    assign win_end   = win_act_q && (win_q == LAST_WIN);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        fetch_d = fetch_q;
        bram_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d = FETCH;
                    mode_d  = mode;
                    base_d  = base_addr;
                    fetch_d = '0;
                end
            end
            FETCH: begin
                bram_en = 1'b1;
                fetch_d = fetch_q + IW'(1);
                if (fetch_q == LAST_IDX) begin
                    fetch_d = '0;
                    state_d = mode_q ? BUFFER : STREAM;
                end
            end
            BUFFER: begin
                if (row_last) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (win_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        col_act_d = col_act_q;
        win_d     = win_q;
        win_act_d = win_act_q;
        done_d    = win_end;
        if (row_vld) begin
            row_d = row_last ? '0 : row_q + IW'(1);
        end
        // Column streaming begins the cycle after the last row lands in the tile buffer.
        if (mode_q && row_last) begin
            col_act_d = 1'b1;
            col_d     = '0;
        end else if (col_act_q) begin
            if (col_q == LAST_IDX) begin
                col_act_d = 1'b0;
                col_d     = '0;
            end else begin
                col_d = col_q + IW'(1);
            end
        end
        if (win_start) begin
            win_act_d = 1'b1;
            win_d     = '0;
        end else if (win_end) begin
            win_act_d = 1'b0;
            win_d     = '0;
        end else if (win_act_q) begin
            win_d = win_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            base_q    <= '0;
            fetch_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            col_act_q <= 1'b0;
            win_q     <= '0;
            win_act_q <= 1'b0;
            done_q    <= 1'b0;
            en_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            base_q    <= base_d;
            fetch_q   <= fetch_d;
            row_q     <= row_d;
            col_q     <= col_d;
            col_act_q <= col_act_d;
            win_q     <= win_d;
            win_act_q <= win_act_d;
            done_q    <= done_d;
            en_pipe_q[0] <= bram_en;
            for (int i = 1; i < RD_LAT; i++) begin
                en_pipe_q[i] <= en_pipe_q[i-1];
            end
        end
    end

    assign bram_addr     = bram_en ? (base_q + BRAM_DEPTH'(fetch_q)) : '0;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign out_valid     = win_act_q;
    assign compute_start = win_act_q && (win_q == '0);

    for (genvar v = 0; v < VECTOR; v++) begin : g_ch
        logic [N-1:0][N-1:0][DATA_WIDTH-1:0] tile_q;
        logic [N-1:0][DATA_WIDTH-1:0]        row_w, col_w, cap_d, cap_q;

        assign row_w = bram_dout[v];

        always_comb begin
            col_w = '0;
            for (int j = 0; j < N; j++) begin
                col_w[j] = tile_q[j][col_q];
            end
        end

        always_comb begin
            cap_d = '0;
            if (mode_q) begin
                if (col_act_q) begin
                    cap_d = col_w;
                end
            end else if (row_vld) begin
                cap_d = row_w;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                tile_q <= '0;
                cap_q  <= '0;
            end else begin
                cap_q <= cap_d;
                if (mode_q && row_vld) begin
                    tile_q[row_q] <= row_w;
                end
            end
        end

        for (genvar j = 0; j < N; j++) begin : g_lane
            skew_line #(
                .DEPTH      (j),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_skew (
                .clk   (clk),
                .reset (reset),
                .d_i   (cap_q[j]),
                .q_o   (lane_out[v][j])
            );
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: N=4, RD_LAT=1, VECTOR=2.
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int V  = 2;
    localparam int BD = 2;
    localparam int RL = 1;
    localparam int NC = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic [BD-1:0] base_addr = '0;
    logic bram_en;
    logic [BD-1:0] bram_addr;
    logic [V-1:0][N*DW-1:0] bram_dout = '0;
    logic [V-1:0][N-1:0][DW-1:0] lane_out;
    logic out_valid, compute_start, busy, done;

    int checks = 0;
    int failures = 0;

    logic [N*DW-1:0] mem [V][1<<BD];

    logic [DW-1:0] o_lane [NC][V][N];
    logic          o_valid [NC];
    logic          o_cs [NC];
    logic          o_busy [NC];
    logic          o_done [NC];
    logic          o_en [NC];
    logic [BD-1:0] o_addr [NC];

    systolic_skew_feeder #(
        .MATRIX_SIZE (N),
        .DATA_WIDTH  (DW),
        .VECTOR      (V),
        .BRAM_DEPTH  (BD),
        .RD_LAT      (RL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mode          (mode),
        .base_addr     (base_addr),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_dout     (bram_dout),
        .lane_out      (lane_out),
        .out_valid     (out_valid),
        .compute_start (compute_start),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency BRAM model
    always @(posedge clk) begin
        if (bram_en) begin
            for (int v = 0; v < V; v++) bram_dout[v] <= mem[v][bram_addr];
        end
    end

    // Reference model: tile row r lives at address base+r (wrapping).
    function automatic logic [DW-1:0] m_elem(int v, int base, int r, int c);
        logic [N*DW-1:0] w;
        w = mem[v][(base + r) % (1 << BD)];
        return w[c*DW +: DW];
    endfunction

    function automatic int t0_of(bit md);
        return md ? (2 + RL + N) : (2 + RL);
    endfunction

    function automatic logic [DW-1:0] exp_lane(int v, int j, int c, bit md, int base);
        int k;
        k = c - t0_of(md) - j;
        if (k < 0 || k >= N) return '0;
        return md ? m_elem(v, base, j, k) : m_elem(v, base, k, j);
    endfunction

    // {bram_en, out_valid, compute_start, busy, done} for cycle c after start at 0
    function automatic logic [4:0] exp_ctl(int c, bit md);
        int t0, last;
        t0 = t0_of(md);
        last = t0 + 3 * N - 3;
        return {(c >= 1 && c <= N), (c >= t0 && c <= last), (c == t0),
                (c >= 1 && c <= last), (c == last + 1)};
    endfunction

    task automatic load_spec;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                mem[0][r][c*DW +: DW] = DW'(4 * r + c + 1);
                mem[1][r][c*DW +: DW] = DW'(100 + 4 * r + c);
            end
        end
    endtask

    task automatic load_random;
        for (int v = 0; v < V; v++)
            for (int a = 0; a < (1 << BD); a++) mem[v][a] = {$urandom, $urandom};
    endtask

    // Starts a tile at cycle 0 and records outputs for NC cycles; ss = extra start
    // (with different mode/base), rc = reset cycle, rs = restart cycle (-1 = none).
    task automatic capture(input bit md, input int base, input int ss, input int rc, input int rs);
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == 0) || (c == ss) || (c == rs);
            reset = (c == rc);
            mode = md;
            base_addr = BD'(base);
            if (c == ss) begin
                mode = ~md;
                base_addr = BD'(base + 1);
            end
            o_valid[c] = out_valid;
            o_cs[c]    = compute_start;
            o_busy[c]  = busy;
            o_done[c]  = done;
            o_en[c]    = bram_en;
            o_addr[c]  = bram_addr;
            for (int v = 0; v < V; v++)
                for (int j = 0; j < N; j++) o_lane[c][v][j] = lane_out[v][j];
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (lane_out !== '0) begin
            failures++; $display("FAIL reset_lanes got=%h exp=0", lane_out);
        end
        checks++;
        if ({bram_en, out_valid, compute_start, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=00000", {bram_en, out_valid, compute_start, busy, done});
        end
        checks++;
        if (bram_addr !== '0) begin
            failures++; $display("FAIL reset_addr got=%0d exp=0", bram_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_row_spec;
        int ncs, nd;
        load_spec();
        capture(1'b0, 0, -1, -1, -1);
        checks++;
        if (o_cs[3] !== 1'b1) begin failures++; $display("FAIL row_cs3 got=%b exp=1", o_cs[3]); end
        checks++;
        if (o_lane[3][0][0] !== 16'd1) begin failures++; $display("FAIL row_l00 got=%0d exp=1", o_lane[3][0][0]); end
        checks++;
        if (o_lane[6][0][2] !== 16'd7) begin failures++; $display("FAIL row_l02 got=%0d exp=7", o_lane[6][0][2]); end
        checks++;
        if (o_lane[9][1][3] !== 16'd115) begin failures++; $display("FAIL row_l13 got=%0d exp=115", o_lane[9][1][3]); end
        ncs = 0; nd = 0;
        for (int c = 0; c < NC; c++) begin
            ncs += int'(o_cs[c]);
            nd  += int'(o_done[c]);
            checks++;
            if (o_valid[c] !== (c >= 3 && c <= 12)) begin
                failures++; $display("FAIL row_valid cyc=%0d got=%b exp=%b", c, o_valid[c], (c >= 3 && c <= 12));
            end
        end
        checks++;
        if (o_done[13] !== 1'b1 || nd != 1) begin
            failures++; $display("FAIL row_done got=%b count=%0d exp=1 count=1", o_done[13], nd);
        end
        checks++;
        if (ncs != 1) begin failures++; $display("FAIL row_cs_count got=%0d exp=1", ncs); end
    endtask

    task automatic test_transpose_spec;
        load_spec();
        capture(1'b1, 0, -1, -1, -1);
        checks++;
        if (o_cs[7] !== 1'b1 || o_cs[3] !== 1'b0) begin
            failures++; $display("FAIL tr_cs got@7=%b got@3=%b exp=1,0", o_cs[7], o_cs[3]);
        end
        checks++;
        if (o_lane[10][0][1] !== 16'd7) begin failures++; $display("FAIL tr_l01 got=%0d exp=7", o_lane[10][0][1]); end
        checks++;
        if (o_lane[13][0][3] !== 16'd16) begin failures++; $display("FAIL tr_l03 got=%0d exp=16", o_lane[13][0][3]); end
        checks++;
        if (o_done[17] !== 1'b1 || o_busy[17] !== 1'b0 || o_busy[16] !== 1'b1) begin
            failures++; $display("FAIL tr_done done17=%b busy17=%b busy16=%b exp=1,0,1", o_done[17], o_busy[17], o_busy[16]);
        end
    endtask

    task automatic test_wrap;
        logic [BD-1:0] exp_a [4];
        exp_a[0] = 2'd3; exp_a[1] = 2'd0; exp_a[2] = 2'd1; exp_a[3] = 2'd2;
        load_random();
        capture(1'b0, 3, -1, -1, -1);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (o_en[c] !== 1'b1 || o_addr[c] !== exp_a[c-1]) begin
                failures++; $display("FAIL wrap_addr cyc=%0d got en=%b addr=%0d exp en=1 addr=%0d", c, o_en[c], o_addr[c], exp_a[c-1]);
            end
        end
        checks++;
        if (o_en[0] !== 1'b0 || o_en[5] !== 1'b0) begin
            failures++; $display("FAIL wrap_en got@0=%b got@5=%b exp=0", o_en[0], o_en[5]);
        end
    endtask

    task automatic test_busy_guard;
        int nd;
        load_spec();
        capture(1'b0, 0, 5, -1, -1);
        nd = 0;
        for (int c = 0; c < NC; c++) nd += int'(o_done[c]);
        checks++;
        if (nd != 1 || o_done[13] !== 1'b1) begin
            failures++; $display("FAIL guard_done count=%0d done13=%b exp count=1 done13=1", nd, o_done[13]);
        end
        checks++;
        if (o_lane[3][0][0] !== 16'd1 || o_lane[9][1][3] !== 16'd115) begin
            failures++; $display("FAIL guard_lanes got=%0d,%0d exp=1,115", o_lane[3][0][0], o_lane[9][1][3]);
        end
        // Start landing exactly on the done cycle must not launch a new tile
        capture(1'b0, 0, 13, -1, -1);
        checks++;
        if (o_busy[14] !== 1'b0 || o_en[14] !== 1'b0) begin
            failures++; $display("FAIL done_cycle_start busy14=%b en14=%b exp=0,0", o_busy[14], o_en[14]);
        end
    endtask

    task automatic test_reset_abort;
        logic [4:0] e, o;
        int nd;
        load_random();
        capture(1'b0, 0, -1, 6, 8);
        nd = 0;
        for (int c = 0; c <= 7; c++) nd += int'(o_done[c]);
        checks++;
        if (nd != 0) begin failures++; $display("FAIL abort_done count=%0d exp=0", nd); end
        for (int c = 0; c < NC; c++) begin
            o = {o_en[c], o_valid[c], o_cs[c], o_busy[c], o_done[c]};
            e = (c <= 6) ? exp_ctl(c, 1'b0) : (c == 7) ? 5'b0 : exp_ctl(c - 8, 1'b0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL abort_ctl cyc=%0d got=%b exp=%b", c, o, e); end
            for (int v = 0; v < V; v++) begin
                for (int j = 0; j < N; j++) begin
                    logic [DW-1:0] el;
                    el = (c <= 6) ? exp_lane(v, j, c, 1'b0, 0) : (c == 7) ? '0 : exp_lane(v, j, c - 8, 1'b0, 0);
                    checks++;
                    if (o_lane[c][v][j] !== el) begin
                        failures++; $display("FAIL abort_lane cyc=%0d v=%0d j=%0d got=%0d exp=%0d", c, v, j, o_lane[c][v][j], el);
                    end
                end
            end
        end
        checks++;
        if (o_cs[11] !== 1'b1) begin failures++; $display("FAIL abort_restart_cs got=%b exp=1", o_cs[11]); end
    endtask

    task automatic test_random;
        logic [4:0] e, o;
        for (int it = 0; it < 10; it++) begin
            bit md;
            int base, ss;
            md = 1'($urandom_range(0, 1));
            base = int'($urandom_range(0, (1 << BD) - 1));
            ss = (it % 2 == 1) ? int'($urandom_range(1, t0_of(md) + 3 * N - 2)) : -1;
            load_random();
            capture(md, base, ss, -1, -1);
            for (int c = 0; c < NC; c++) begin
                e = exp_ctl(c, md);
                o = {o_en[c], o_valid[c], o_cs[c], o_busy[c], o_done[c]};
                checks++;
                if (o !== e) begin
                    failures++; $display("FAIL rand_ctl it=%0d md=%0d cyc=%0d got=%b exp=%b", it, md, c, o, e);
                end
                if (e[4]) begin
                    checks++;
                    if (o_addr[c] !== BD'(base + c - 1)) begin
                        failures++; $display("FAIL rand_addr it=%0d cyc=%0d got=%0d exp=%0d", it, c, o_addr[c], BD'(base + c - 1));
                    end
                end
                for (int v = 0; v < V; v++) begin
                    for (int j = 0; j < N; j++) begin
                        checks++;
                        if (o_lane[c][v][j] !== exp_lane(v, j, c, md, base)) begin
                            failures++;
                            $display("FAIL rand_lane it=%0d md=%0d cyc=%0d v=%0d j=%0d got=%0d exp=%0d",
                                     it, md, c, v, j, o_lane[c][v][j], exp_lane(v, j, c, md, base));
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_row_spec();
        test_transpose_spec();
        test_wrap();
        test_busy_guard();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
